tea_iterative_engine: RTL and testbench
=======================================

Name: tea_iterative_engine

Overview:
- Iterative TEA encrypt/decrypt engine with a valid/ready handshake. It is the area-reduced alternative to the fully unrolled 32-round combinational encryptor.
- It time-multiplexes one encrypt round and one decrypt round over ROUNDS cycles per 64-bit block. It sequences the running sum and holds the result until the consumer takes it.
- It sits between the block-mode front end (ECB/CBC framing) and the output buffer.

Parameters:
- ROUNDS, 32, number of TEA cycles per block; legal range 1..63.
- DELTA, 32'h9E37_79B9, TEA key-schedule constant.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ena  in  1  round-progress enable; 0 stalls computation only.
- in_valid  in  1  producer has a block.
- in_ready  out  1  engine can accept a block.
- in_block  in  64  block; [31:0]=V0, [63:32]=V1.
- in_key  in  128  key; k0=[31:0] … k3=[127:96].
- in_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled with the block.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_block  out  64  result; same V0/V1 packing as in_block.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst=0, async): state=IDLE, in_ready=1, out_valid=0, busy=0, out_block=0, round counter=0, sum=0, latched key/mode=0.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid && in_ready. This latches in_block into V0/V1, in_key, and in_decrypt.
  - Set cnt=0.
  - Set sum to DELTA for encrypt, or to DELTA*ROUNDS mod 2^32 for decrypt (ROUNDS=32 gives 32'hC6EF_3720).
  - Go to RUN. ena has no effect on acceptance.
- RUN:
  - in_ready=0.
  - Each cycle with ena=1, V0/V1 are replaced by the selected round output:
    - encrypt round: V0+=((V1<<4)+k0)^(V1+sum)^((V1>>5)+k1), then V1+=((V0'<<4)+k2)^(V0'+sum)^((V0'>>5)+k3);
    - decrypt round: the exact inverse, updating V1 first, then V0.
  - After the same cycle, sum+=DELTA (encrypt) or sum-=DELTA (decrypt), and cnt+=1.
  - When cnt==ROUNDS-1 and ena=1, the final round is applied and the state goes to DONE.
  - ena=0: V0, V1, sum and cnt hold.
- Arithmetic: all adds, subtracts and shifts are 32-bit unsigned, modulo 2^32. >> is logical. Shifted-out bits are discarded.
- DONE:
  - out_valid=1 and out_block=V1:V0. Both stay stable until out_ready=1.
  - On out_valid && out_ready the state goes to IDLE and out_valid drops next cycle.
  - No same-cycle re-accept: in_ready is 0 in DONE.
- Latency: accept in cycle 0, rounds in cycles 1..ROUNDS (with ena=1 throughout), out_valid high from cycle ROUNDS+1. Throughput is one block per ROUNDS+2 cycles.
- Input changes while not in IDLE are ignored; in_block, in_key and in_decrypt are only sampled at accept.
- Reset mid-RUN or mid-DONE aborts the block without emitting it and returns to IDLE immediately.
- Reset asserted in the same cycle as an accept: reset wins and nothing is latched.

Decomposition:
- Shared package tea_pkg holds:
  - DELTA_C = 32'h9E37_79B9 and DEC_SUM32_C = 32'hC6EF_3720;
  - state enum {ST_IDLE, ST_RUN, ST_DONE};
  - 6-bit round-counter width.
- The encrypt round is the team's existing combinational single-round encryptor, instantiated once.
- New sub-module tea_decrypt_single_round is added: combinational, same port shape (key, inV0, inV1, sum, outputV0, outputV1), implementing the inverse round.
- The engine muxes between the two round outputs with the latched mode bit.

Test Plan:
- Encrypt known vector: key=0, block=0, decrypt=0, ena=1, out_ready=1 -> out_valid at cycle 33, out_block=64'h94BAA940_41EA3A0A, back to IDLE at cycle 34.
- Decrypt round-trip: key=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, block=64'hDEAD_BEEF_0BAD_F00D. Encrypt, then feed the result back with decrypt=1 -> out_block=64'hDEAD_BEEF_0BAD_F00D; compare both passes against a C reference model.
- Stall: encrypt zero vector with ena=0 for 5 cycles mid-RUN -> result unchanged, out_valid at cycle 38.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_block stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> one transfer, then IDLE.
- Reset mid-operation: assert rst=0 at round 17 -> out_valid=0 and in_ready=1 immediately. A following zero-vector encrypt gives 64'h94BAA940_41EA3A0A.
- Input isolation: change in_block, in_key and in_decrypt every cycle during RUN -> result matches the values latched at accept.

Source files
------------

// File: rtl/tea_pkg.sv
// Shared TEA constants, FSM state encoding and the round mixing function.
package tea_pkg;

  localparam logic [31:0] DELTA_C     = 32'h9E37_79B9;
  localparam logic [31:0] DEC_SUM32_C = 32'hC6EF_3720;
  localparam int unsigned CNT_W       = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One Feistel half-round term: ((v<<4)+ka) ^ (v+sum) ^ ((v>>5)+kb)
  function automatic logic [31:0] tea_mix(input logic [31:0] v,
                                          input logic [31:0] sum,
                                          input logic [31:0] ka,
                                          input logic [31:0] kb);
    return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
  endfunction

  // delta * rounds mod 2^32, the starting sum of a decrypt pass
  function automatic logic [31:0] tea_sum_mult(input logic [31:0] delta,
                                               input int unsigned rounds);
    logic [63:0] prod;
    prod = 64'(delta) * 64'(rounds);
    return prod[31:0];
  endfunction

endpackage

// File: rtl/tea_decrypt_single_round.sv
// Combinational single TEA decrypt round: exact inverse of the encrypt round.
module tea_decrypt_single_round
  import tea_pkg::*;
(
  input  logic [127:0] key,
  input  logic [31:0]  inV0,
  input  logic [31:0]  inV1,
  input  logic [31:0]  sum,
  output logic [31:0]  outputV0,
  output logic [31:0]  outputV1
);

  logic [31:0] v1_new;

  always_comb begin
    v1_new   = inV1 - tea_mix(inV0, sum, key[95:64], key[127:96]);
    outputV1 = v1_new;
    outputV0 = inV0 - tea_mix(v1_new, sum, key[31:0], key[63:32]);
  end

endmodule

// File: rtl/tea_encrypt_single_round.sv
// Combinational single TEA encrypt round: V0 updated first, then V1 from the new V0.
module tea_encrypt_single_round
  import tea_pkg::*;
(
  input  logic [127:0] key,
  input  logic [31:0]  inV0,
  input  logic [31:0]  inV1,
  input  logic [31:0]  sum,
  output logic [31:0]  outputV0,
  output logic [31:0]  outputV1
);

  logic [31:0] v0_new;

  always_comb begin
    v0_new   = inV0 + tea_mix(inV1, sum, key[31:0], key[63:32]);
    outputV0 = v0_new;
    outputV1 = inV1 + tea_mix(v0_new, sum, key[95:64], key[127:96]);
  end

endmodule

// File: rtl/tea_iterative_engine.sv
// Iterative TEA engine: one encrypt and one decrypt round reused over ROUNDS cycles per block.
module tea_iterative_engine
  import tea_pkg::*;
#(
  parameter int unsigned ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E37_79B9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_block,
  input  logic [127:0] in_key,
  input  logic         in_decrypt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_block,
  output logic         busy
);

  localparam logic [CNT_W-1:0] LAST_CNT_C = CNT_W'(ROUNDS - 1);
  localparam logic [31:0] DEC_SUM_INIT_C =
    (ROUNDS == 32 && DELTA == DELTA_C) ? DEC_SUM32_C : tea_sum_mult(DELTA, ROUNDS);

  state_e             state_q, state_d;
  logic [31:0]        v0_q, v0_d, v1_q, v1_d;
  logic [31:0]        sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       key_q, key_d;
  logic               dec_q, dec_d;

  logic [31:0]        enc_v0, enc_v1, dec_v0, dec_v1;

  tea_encrypt_single_round u_enc (
    .key      (key_q),
    .inV0     (v0_q),
    .inV1     (v1_q),
    .sum      (sum_q),
    .outputV0 (enc_v0),
    .outputV1 (enc_v1)
  );

  tea_decrypt_single_round u_dec (
    .key      (key_q),
    .inV0     (v0_q),
    .inV1     (v1_q),
    .sum      (sum_q),
    .outputV0 (dec_v0),
    .outputV1 (dec_v1)
  );

  always_comb begin
    state_d = state_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    dec_d   = dec_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          v0_d    = in_block[31:0];
          v1_d    = in_block[63:32];
          key_d   = in_key;
          dec_d   = in_decrypt;
          cnt_d   = '0;
          sum_d   = in_decrypt ? DEC_SUM_INIT_C : DELTA;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (ena) begin
          v0_d  = dec_q ? dec_v0 : enc_v0;
          v1_d  = dec_q ? dec_v1 : enc_v1;
          sum_d = dec_q ? (sum_q - DELTA) : (sum_q + DELTA);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT_C) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      v0_q    <= '0;
      v1_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      dec_q   <= dec_d;
    end
  end

  // The result bus is only meaningful in DONE; intermediate rounds stay hidden.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_block = out_valid ? {v1_q, v0_q} : '0;

endmodule

// File: tb/tb_tea_iterative_engine.sv
// Directed bench for tea_iterative_engine with an independent C-style TEA reference.
module tb_tea_iterative_engine;

  logic         clk;
  logic         rst;
  logic         ena;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_block;
  logic [127:0] in_key;
  logic         in_decrypt;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_block;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;
  int edges    = 0;
  bit scramble = 0;

  localparam logic [63:0]  ZERO_CT = 64'h94BA_A940_41EA_3A0A;
  localparam logic [127:0] RT_KEY  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [63:0]  RT_PT   = 64'hDEAD_BEEF_0BAD_F00D;

  tea_iterative_engine #(.ROUNDS(32), .DELTA(32'h9E37_79B9)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_block   (in_block),
    .in_key     (in_key),
    .in_decrypt (in_decrypt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] tea_ref(input logic [63:0] blk, input logic [127:0] k,
                                          input bit dec);
    logic [31:0] v0, v1, s, k0, k1, k2, k3;
    v0 = blk[31:0];  v1 = blk[63:32];
    k0 = k[31:0];    k1 = k[63:32];  k2 = k[95:64];  k3 = k[127:96];
    s  = dec ? 32'hC6EF_3720 : 32'h0;
    for (int i = 0; i < 32; i++) begin
      if (!dec) begin
        s  += 32'h9E37_79B9;
        v0 += ((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1);
        v1 += ((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3);
      end else begin
        v1 -= ((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3);
        v0 -= ((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1);
        s  -= 32'h9E37_79B9;
      end
    end
    return {v1, v0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
    if (scramble) begin
      in_block   = {$urandom, $urandom};
      in_key     = {$urandom, $urandom, $urandom, $urandom};
      in_decrypt = 1'($urandom_range(0, 1));
    end
  endtask

  // Presents one block, lets the accept edge pass, and restarts the edge count.
  task automatic start_block(input logic [63:0] blk, input logic [127:0] key, input logic dec);
    @(negedge clk);
    in_valid   = 1'b1;
    in_block   = blk;
    in_key     = key;
    in_decrypt = dec;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    edges    = 0;
  endtask

  // Returns the cycle index (accept = cycle 0) where out_valid appears, 0 on timeout.
  task automatic wait_done(output int cyc);
    for (int k = 0; k < 300; k++) begin
      if (out_valid) break;
      step();
    end
    cyc = out_valid ? edges + 1 : 0;
  endtask

  initial begin
    int          lat;
    logic [63:0] enc, held;

    rst = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_block = '0; in_key = '0; in_decrypt = 1'b0;
    #2;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_out_block", out_block,      64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Zero-key zero-block known answer with timing
    start_block(64'd0, 128'd0, 1'b0);
    chk("enc0_busy_run", 64'(busy),     64'd1);
    chk("enc0_ready_run", 64'(in_ready), 64'd0);
    wait_done(lat);
    chk("enc0_latency", 64'(lat), 64'd33);
    chk("enc0_block",   out_block, ZERO_CT);
    step();
    chk("enc0_idle_cycle", 64'(edges + 1), 64'd34);
    chk("enc0_idle_ready", 64'(in_ready),  64'd1);
    chk("enc0_idle_valid", 64'(out_valid), 64'd0);
    chk("enc0_idle_busy",  64'(busy),      64'd0);

    // Encrypt / decrypt round trip
    start_block(RT_PT, RT_KEY, 1'b0);
    wait_done(lat);
    enc = out_block;
    chk("rt_enc_latency", 64'(lat), 64'd33);
    chk("rt_enc_model",   enc, tea_ref(RT_PT, RT_KEY, 1'b0));
    step();
    start_block(enc, RT_KEY, 1'b1);
    wait_done(lat);
    chk("rt_dec_latency", 64'(lat), 64'd33);
    chk("rt_dec_plain",   out_block, RT_PT);
    chk("rt_dec_model",   out_block, tea_ref(enc, RT_KEY, 1'b1));
    step();

    // Stall for 5 cycles mid-run
    start_block(64'd0, 128'd0, 1'b0);
    repeat (10) step();
    ena = 1'b0;
    repeat (5) step();
    chk("stall_busy", 64'(busy), 64'd1);
    ena = 1'b1;
    wait_done(lat);
    chk("stall_latency", 64'(lat), 64'd38);
    chk("stall_block",   out_block, ZERO_CT);
    step();

    // Backpressure in DONE with ignored in_valid pulses
    out_ready = 1'b0;
    start_block(64'd0, 128'd0, 1'b0);
    wait_done(lat);
    chk("bp_latency", 64'(lat), 64'd33);
    held = out_block;
    chk("bp_block", held, ZERO_CT);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      in_block = {$urandom, $urandom};
      step();
      chk("bp_valid_hold", 64'(out_valid), 64'd1);
      chk("bp_block_hold", out_block,      held);
      chk("bp_in_ready",   64'(in_ready),  64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_xfer_valid", 64'(out_valid), 64'd0);
    chk("bp_xfer_ready", 64'(in_ready),  64'd1);
    step();
    chk("bp_single_xfer", 64'(out_valid), 64'd0);

    // Reset at round 17 aborts the block
    start_block(64'd0, 128'd0, 1'b0);
    repeat (17) step();
    rst = 1'b0;
    #1;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_ready", 64'(in_ready),  64'd1);
    chk("abort_busy",  64'(busy),      64'd0);
    @(negedge clk);
    rst = 1'b1;
    start_block(64'd0, 128'd0, 1'b0);
    wait_done(lat);
    chk("post_abort_latency", 64'(lat), 64'd33);
    chk("post_abort_block",   out_block, ZERO_CT);
    step();

    // Reset coincident with an accept: nothing is latched
    @(negedge clk);
    in_valid = 1'b1;
    rst      = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_accept_busy",  64'(busy),     64'd0);
    chk("rst_accept_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("rst_accept_idle", 64'(busy), 64'd0);

    // Inputs scrambled every cycle during RUN
    scramble = 1'b1;
    start_block(64'd0, 128'd0, 1'b0);
    wait_done(lat);
    scramble   = 1'b0;
    in_block   = '0;
    in_key     = '0;
    in_decrypt = 1'b0;
    chk("iso_latency", 64'(lat), 64'd33);
    chk("iso_block",   out_block, ZERO_CT);
    step();
    chk("iso_idle", 64'(in_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
